// File: rtl/wb_port_arbiter_pkg.sv
// ============================================================================
// wb_port_arbiter_pkg : shared widths, constants and types for the
//                       write-back port arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package wb_port_arbiter_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  // Architectural $0: writes are discarded, reads never forward.
  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_DRAIN = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
// ============================================================================
// wb_port_arbiter_if : MEM/WR lanes, regfile write port, stall and ID-stage
//                      forwarding ports
// Revision: 1.0
// ============================================================================
`default_nettype none

interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              l0_wr;
  logic [ADDR_W-1:0] l0_addr;
  logic [DATA_W-1:0] l0_data;
  logic              l1_wr;
  logic [ADDR_W-1:0] l1_addr;
  logic [DATA_W-1:0] l1_data;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              stall;

  logic [ADDR_W-1:0] rd0_addr;
  logic              rd0_hit;
  logic [DATA_W-1:0] rd0_data;
  logic [ADDR_W-1:0] rd1_addr;
  logic              rd1_hit;
  logic [DATA_W-1:0] rd1_data;

  // Pipeline side: drives lanes and read addresses.
  modport master (
    output l0_wr, l0_addr, l0_data, l1_wr, l1_addr, l1_data,
    output rd0_addr, rd1_addr,
    input  rf_we, rf_waddr, rf_wdata, stall,
    input  rd0_hit, rd0_data, rd1_hit, rd1_data
  );

  // Arbiter side.
  modport slave (
    input  l0_wr, l0_addr, l0_data, l1_wr, l1_addr, l1_data,
    input  rd0_addr, rd1_addr,
    output rf_we, rf_waddr, rf_wdata, stall,
    output rd0_hit, rd0_data, rd1_hit, rd1_data
  );

endinterface

`default_nettype wire

// File: rtl/wb_port_arbiter_fwd_mux.sv
// ============================================================================
// wb_fwd_mux : one ID read port's match and priority select over the two
//              pending write sources (hold entry, then rf register)
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_fwd_mux
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              hold_valid,
  input  logic [ADDR_W-1:0] hold_addr,
  input  logic [DATA_W-1:0] hold_data,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (rd_addr != ADDR_W'(REG_ZERO)) begin
      // Hold entry is younger than the rf register, so it wins.
      if (hold_valid && (hold_addr == rd_addr)) begin
        hit  = 1'b1;
        data = hold_data;
      end else if (rf_we && (rf_waddr == rd_addr)) begin
        hit  = 1'b1;
        data = rf_wdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// wb_port_arbiter : serialises dual MEM/WR writes onto one regfile write port
//                   and forwards pending writes to the ID read ports
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_port_arbiter_if.slave    bus,
  output logic [CNT_W-1:0]    conflict_cnt,
  output logic                proto_err
);

  arb_state_t        state;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  cnt;
  logic              perr;

  logic hold_valid;
  logic l0_v;
  logic l1_v;
  logic dual_conflict;

  assign hold_valid    = (state == ARB_DRAIN);
  assign l0_v          = bus.l0_wr && (bus.l0_addr != ADDR_W'(REG_ZERO));
  assign l1_v          = bus.l1_wr && (bus.l1_addr != ADDR_W'(REG_ZERO));
  // Only IDLE can see a conflict, so a stall is never followed by another.
  assign dual_conflict = !hold_valid && l0_v && l1_v && (bus.l0_addr != bus.l1_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      hold_addr <= '0;
      hold_data <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      cnt       <= '0;
      perr      <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (dual_conflict) begin
            rf_we     <= 1'b1;
            rf_waddr  <= bus.l0_addr;
            rf_wdata  <= bus.l0_data;
            hold_addr <= bus.l1_addr;
            hold_data <= bus.l1_data;
            state     <= ARB_DRAIN;
            if (cnt != {CNT_W{1'b1}}) begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (l1_v) begin
            // Lane 1 alone, or a WAW pair where the younger lane survives.
            rf_we    <= 1'b1;
            rf_waddr <= bus.l1_addr;
            rf_wdata <= bus.l1_data;
          end else if (l0_v) begin
            rf_we    <= 1'b1;
            rf_waddr <= bus.l0_addr;
            rf_wdata <= bus.l0_data;
          end else begin
            rf_we <= 1'b0;
          end
        end
        ARB_DRAIN: begin
          rf_we    <= 1'b1;
          rf_waddr <= hold_addr;
          rf_wdata <= hold_data;
          state    <= ARB_IDLE;
          if (l0_v || l1_v) begin
            perr <= 1'b1;
          end
        end
        default: begin
          state <= ARB_IDLE;
          rf_we <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rf_we     = rf_we;
  assign bus.rf_waddr  = rf_waddr;
  assign bus.rf_wdata  = rf_wdata;
  assign bus.stall     = dual_conflict;
  assign conflict_cnt  = cnt;
  assign proto_err     = perr;

  wb_fwd_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd_rd0 (
    .rd_addr    (bus.rd0_addr),
    .hold_valid (hold_valid),
    .hold_addr  (hold_addr),
    .hold_data  (hold_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .hit        (bus.rd0_hit),
    .data       (bus.rd0_data)
  );

  wb_fwd_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd_rd1 (
    .rd_addr    (bus.rd1_addr),
    .hold_valid (hold_valid),
    .hold_addr  (hold_addr),
    .hold_data  (hold_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .hit        (bus.rd1_hit),
    .data       (bus.rd1_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// tb_wb_port_arbiter : directed and randomized checks of wb_port_arbiter
//                      against a write-queue reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] conflict_cnt;
  logic             proto_err;

  wb_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_port_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .conflict_cnt (conflict_cnt),
    .proto_err    (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Model: writes waiting for the port, in age order, plus what the port
  // is presenting this cycle.
  wb_entry          m_q[$];
  wb_entry          m_rf;
  logic [CNT_W-1:0] m_cnt;
  bit               m_proto;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rf    = '0;
    m_cnt   = '0;
    m_proto = 1'b0;
  endtask

  function automatic bit lane_valid(input logic wr, input logic [ADDR_W-1:0] a);
    return wr && (a != 0);
  endfunction

  function automatic bit exp_stall();
    bit v0 = lane_valid(bus.l0_wr, bus.l0_addr);
    bit v1 = lane_valid(bus.l1_wr, bus.l1_addr);
    return (m_q.size() == 0) && v0 && v1 && (bus.l0_addr != bus.l1_addr);
  endfunction

  // Youngest pending write to addr wins; $0 never forwards.
  task automatic exp_fwd(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 0) begin
      if (m_rf.valid && m_rf.addr == a) begin
        hit = 1'b1;
        d   = m_rf.data;
      end
      foreach (m_q[i]) begin
        if (m_q[i].addr == a) begin
          hit = 1'b1;
          d   = m_q[i].data;
        end
      end
    end
  endtask

  task automatic model_edge();
    wb_entry nw[$];
    bit v0 = lane_valid(bus.l0_wr, bus.l0_addr);
    bit v1 = lane_valid(bus.l1_wr, bus.l1_addr);
    wb_entry e0 = '{valid: 1'b1, addr: bus.l0_addr, data: bus.l0_data};
    wb_entry e1 = '{valid: 1'b1, addr: bus.l1_addr, data: bus.l1_data};
    if (m_q.size() != 0) begin
      m_rf = m_q.pop_front();
      if (v0 || v1) m_proto = 1'b1;
    end else begin
      if (v0) nw.push_back(e0);
      if (v1) begin
        if (v0 && bus.l0_addr == bus.l1_addr) nw[0] = e1;
        else nw.push_back(e1);
      end
      if (nw.size() == 0) m_rf = '0;
      else m_rf = nw.pop_front();
      if (nw.size() != 0) begin
        m_q = nw;
        if (m_cnt != (2**CNT_W) - 1) m_cnt = m_cnt + 1'b1;
      end
    end
  endtask

  task automatic pre_checks();
    logic             h;
    logic [DATA_W-1:0] d;
    chk("stall", bus.stall, exp_stall());
    exp_fwd(bus.rd0_addr, h, d);
    chk("rd0_hit", bus.rd0_hit, h);
    chk("rd0_data", bus.rd0_data, d);
    exp_fwd(bus.rd1_addr, h, d);
    chk("rd1_hit", bus.rd1_hit, h);
    chk("rd1_data", bus.rd1_data, d);
  endtask

  task automatic drive(input logic w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                       input logic [ADDR_W-1:0] r0, input logic [ADDR_W-1:0] r1);
    @(negedge clk);
    bus.l0_wr = w0; bus.l0_addr = a0; bus.l0_data = d0;
    bus.l1_wr = w1; bus.l1_addr = a1; bus.l1_data = d1;
    bus.rd0_addr = r0; bus.rd1_addr = r1;
    #1;
    pre_checks();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    #1;
    chk("rf_we", bus.rf_we, m_rf.valid);
    if (m_rf.valid) begin
      chk("rf_waddr", bus.rf_waddr, m_rf.addr);
      chk("rf_wdata", bus.rf_wdata, m_rf.data);
    end
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("proto_err", proto_err, m_proto);
  endtask

  task automatic step(input logic w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                      input logic w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                      input logic [ADDR_W-1:0] r0, input logic [ADDR_W-1:0] r1);
    drive(w0, a0, d0, w1, a1, d1, r0, r1);
    clock_edge();
  endtask

  task automatic bubble();
    step(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.l0_wr = 1'b0; bus.l0_addr = '0; bus.l0_data = '0;
    bus.l1_wr = 1'b0; bus.l1_addr = '0; bus.l1_data = '0;
    bus.rd0_addr = '0; bus.rd1_addr = '0;
    model_reset();
    #1;
    chk("reset_rf_we", bus.rf_we, 1'b0);
    chk("reset_rf_waddr", bus.rf_waddr, '0);
    chk("reset_rf_wdata", bus.rf_wdata, '0);
    chk("reset_cnt", conflict_cnt, '0);
    chk("reset_proto", proto_err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    model_reset();
    #2;
    do_reset();

    // Single write, one-cycle latency.
    step(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, '0, '0, '0, '0);
    chk("t1_rf_we", bus.rf_we, 1'b1);
    chk("t1_waddr", bus.rf_waddr, 8);
    chk("t1_wdata", bus.rf_wdata, 32'hDEADBEEF);
    chk("t1_stall", bus.stall, 1'b0);

    // Dual write with forwarding from both pending sources in N+1.
    drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, '0, '0);
    chk("t2_stall", bus.stall, 1'b1);
    clock_edge();
    chk("t2_n1_waddr", bus.rf_waddr, 5);
    chk("t2_n1_wdata", bus.rf_wdata, 32'h11);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd6, 5'd5);
    chk("t4_rd0_hit", bus.rd0_hit, 1'b1);
    chk("t4_rd0_data", bus.rd0_data, 32'h22);
    chk("t4_rd1_hit", bus.rd1_hit, 1'b1);
    chk("t4_rd1_data", bus.rd1_data, 32'h11);
    chk("t4_n1_stall", bus.stall, 1'b0);
    clock_edge();
    chk("t2_n2_waddr", bus.rf_waddr, 6);
    chk("t2_n2_wdata", bus.rf_wdata, 32'h22);
    chk("t2_cnt", conflict_cnt, 1);
    step(1'b0, '0, '0, 1'b0, '0, '0, '0, 5'd6);
    chk("t4_rd_zero", bus.rd0_hit, 1'b0);

    // WAW: younger lane wins, no stall, no count.
    drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, '0, '0);
    chk("t3_stall", bus.stall, 1'b0);
    clock_edge();
    chk("t3_wdata", bus.rf_wdata, 32'h2);
    chk("t3_cnt", conflict_cnt, 1);
    bubble();
    chk("t3_single", bus.rf_we, 1'b0);

    // $0 write dropped; lane write during DRAIN ignored and flagged.
    step(1'b1, 5'd0, 32'h55, 1'b0, '0, '0, '0, '0);
    chk("t5_zero", bus.rf_we, 1'b0);
    step(1'b1, 5'd9, 32'hA, 1'b1, 5'd10, 32'hB, '0, '0);
    step(1'b1, 5'd11, 32'hC, 1'b0, '0, '0, '0, '0);
    chk("t5_drain_addr", bus.rf_waddr, 10);
    chk("t5_proto", proto_err, 1'b1);
    bubble();
    chk("t5_ignored", bus.rf_we, 1'b0);

    // Randomized traffic that keeps lanes bubbled while a write is held.
    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0] r0 = ADDR_W'($urandom_range(0, 7));
      logic [ADDR_W-1:0] r1 = ADDR_W'($urandom_range(0, 7));
      if (m_q.size() != 0)
        step(1'($urandom), '0, $urandom, 1'($urandom), '0, $urandom, r0, r1);
      else
        step(1'($urandom), ADDR_W'($urandom_range(0, 7)), $urandom,
             1'($urandom), ADDR_W'($urandom_range(0, 7)), $urandom, r0, r1);
    end
    chk("rand_proto_sticky", proto_err, 1'b1);

    // Asynchronous reset while the held write is pending.
    bubble();
    drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, '0, '0);
    clock_edge();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd6, 5'd5);
    #2;
    do_reset();
    bus.rd0_addr = 5'd6;
    bus.rd1_addr = 5'd5;
    #1;
    chk("t6_rd0_hit", bus.rd0_hit, 1'b0);
    chk("t6_rd1_hit", bus.rd1_hit, 1'b0);
    step(1'b0, '0, '0, 1'b0, '0, '0, 5'd6, 5'd5);
    chk("t6_no_drain", bus.rf_we, 1'b0);
    bubble();
    chk("t6_no_drain2", bus.rf_we, 1'b0);

    // Counter saturation: 2^CNT_W+3 conflicts.
    for (int i = 0; i < (2**CNT_W) + 3; i++) begin
      step(1'b1, 5'd1, 32'(i), 1'b1, 5'd2, 32'(i + 100), '0, '0);
      bubble();
    end
    chk("t6_cnt_sat", conflict_cnt, {CNT_W{1'b1}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
